mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the datapath's memory interface: accepts read/write requests addressed by the 9-bit MAR output, with write data from the MDR path.
- Holds a synchronous word-addressed RAM (default 512 x 32) and inserts a configurable number of wait states.
- Signals completion with a one-cycle `done` pulse; returns read data on `rdata`, held stable until the next read completes.
- Sits between MAR/MDR and the control unit's memory-access states.

Parameters:
- ADDR_W, 9, address width; matches MAR output width.
- DATA_W, 32, data word width.
- DEPTH, 512, number of implemented words; must satisfy DEPTH <= 2^ADDR_W.
- WAIT_CYCLES, 2, wait states inserted before the array access; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous, active-low reset; clr = 0 at a rising edge resets the block.
- addr  input  ADDR_W  word address, from MAR.
- wdata  input  DATA_W  write data, from MDR.
- read  input  1  read request, level; held by the requester until `done` is seen.
- write  input  1  write request, level; held by the requester until `done` is seen.
- rdata  output  DATA_W  read data; updated only on read completion.
- busy  output  1  high while a transaction is in flight.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle error pulse.

Behaviour:
- Reset (clr = 0 at an edge):
  - state = IDLE, counter = 0, rdata = 0, busy = 0, done = 0, err = 0.
  - RAM contents are NOT cleared by reset; they initialise to all-zero at time 0.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - Samples read/write at each edge.
  - Exactly one asserted: latch addr, wdata and op; busy = 1; counter = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, otherwise ACCESS.
  - Both asserted: err = 1 for one cycle, no access, stay in IDLE, busy stays 0.
  - Neither asserted: hold.
- WAIT:
  - Decrement counter each edge; go to ACCESS on the edge where counter == 1.
  - read, write, addr and wdata are ignored; the latched copies are used.
- ACCESS (one cycle):
  - Latched address < DEPTH:
    - Write: mem[addr] <= wdata.
    - Read: rdata <= mem[addr].
  - Latched address >= DEPTH:
    - Write is dropped.
    - Read sets rdata <= 0.
    - err = 1 in the same cycle as done.
  - Set done = 1; go to DONE.
- DONE:
  - done and err clear at the next edge; busy = 0; go to IDLE.
  - Requests are not sampled in DONE, so a held request cannot retrigger.
- Latency, with edge 0 = the IDLE edge that samples the request:
  - done is high during the cycle after edge WAIT_CYCLES+1, for exactly one cycle.
  - busy is high from edge 0 until edge WAIT_CYCLES+2.
  - Back-to-back throughput is one transaction per WAIT_CYCLES+3 cycles.
- Protocol: the requester drops read/write in the cycle it sees done. A request still held when IDLE is re-entered starts a new transaction.
- Read-after-write to the same address returns the newly written value; the write is committed at the ACCESS edge, before any later read.
- rdata is unchanged by writes, errors and idle cycles.
- Reset mid-transaction:
  - Before the ACCESS edge: abort, memory unchanged, no done pulse.
  - On or after the ACCESS edge: a completed write remains in memory; done/err are cleared.
- Simultaneous reset and request: reset wins; the request is ignored that edge.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x005 with WAIT_CYCLES = 2 -> busy rises after edge 0, done pulses one cycle after edge 3, busy falls after edge 4.
- Then read addr 0x005 -> rdata = 0xDEADBEEF when done is high; rdata holds through 10 idle cycles.
- read = write = 1 at addr 0x010 -> err pulses one cycle, busy stays 0, no done; a following read of 0x010 returns 0x00000000.
- WAIT_CYCLES = 0: write 0x1 to addr 0x1FF, then read it back -> done one cycle after the sampling edge; rdata = 0x00000001; a back-to-back read request held through DONE starts exactly one cycle later.
- Write 0xAAAA5555 to addr 0x020 and pull clr low during WAIT -> done never pulses, all outputs are 0; reading 0x020 afterwards returns the prior contents (0).
- DEPTH = 256, read addr 0x100 -> done and err pulse together, rdata = 0; a write to 0x100 leaves every in-range location unchanged.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: word-addressed synchronous RAM behind a read/write
// level-request port, with programmable wait states and one-cycle done/err pulses.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Handshake: read/write are levels held until done is seen; exactly one
  // asserted starts a transaction in IDLE, both asserted is rejected with err.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int            IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]    WAIT_L  = 4'(WAIT_CYCLES);
  localparam state_t        FIRST_S = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;

  state_t              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic                op_wr_q, op_wr_n;
  logic                busy_n, done_n, err_n;
  logic                in_range;
  logic [IDX_W-1:0]    idx;

  // Contents survive reset; zero only at power-up.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  assign in_range  = {1'b0, addr_q} < DEPTH_L;
  assign idx       = addr_q[IDX_W-1:0];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      op_wr_q <= op_wr_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    op_wr_n = op_wr_q;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (read ^ write) begin
          addr_n  = addr;
          wdata_n = wdata;
          op_wr_n = write;
          busy_n  = 1'b1;
          cnt_n   = WAIT_L;
          state_n = FIRST_S;
        end else if (read && write) begin
          err_n = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = S_ACCESS;
      end
      S_ACCESS: begin
        done_n  = 1'b1;
        err_n   = !in_range;
        state_n = S_DONE;
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // The array write ignores clr so a write whose ACCESS edge coincides with
  // reset still commits.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && op_wr_q && in_range) mem[idx] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      rdata <= '0;
    end else if (state == S_ACCESS && !op_wr_q) begin
      rdata <= in_range ? mem[idx] : '0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances cover WAIT_CYCLES=2,
// WAIT_CYCLES=0 and a DEPTH=256 array with out-of-range addresses.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic [8:0]  addr  [3];
  logic [31:0] wdata [3];
  logic        read  [3];
  logic        write [3];
  logic [31:0] rdata [3];
  logic        busy  [3];
  logic        done  [3];
  logic        err   [3];
  logic [1:0]  dbg   [3];

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(2)) u0 (
    .clk(clk), .clr(clr), .addr(addr[0]), .wdata(wdata[0]), .read(read[0]),
    .write(write[0]), .rdata(rdata[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .dbg_state(dbg[0]));

  mem_responder #(.WAIT_CYCLES(0)) u1 (
    .clk(clk), .clr(clr), .addr(addr[1]), .wdata(wdata[1]), .read(read[1]),
    .write(write[1]), .rdata(rdata[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .dbg_state(dbg[1]));

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .clr(clr), .addr(addr[2]), .wdata(wdata[2]), .read(read[2]),
    .write(write[2]), .rdata(rdata[2]), .busy(busy[2]), .done(done[2]),
    .err(err[2]), .dbg_state(dbg[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int u, input logic b,
                           input logic d, input logic e);
    check({tag, ".busy"}, 32'(busy[u]), 32'(b));
    check({tag, ".done"}, 32'(done[u]), 32'(d));
    check({tag, ".err"},  32'(err[u]),  32'(e));
  endtask

  // Drives one transaction and checks busy/done/err cycle by cycle; the
  // request is dropped in the cycle done is seen.
  task automatic run_txn(input string tag, input int u, input bit is_wr,
                         input logic [8:0] a, input logic [31:0] d, input int wc,
                         input bit exp_err, input logic [31:0] exp_rdata);
    addr[u]  = a;
    wdata[u] = d;
    read[u]  = !is_wr;
    write[u] = is_wr;
    tick();
    for (int k = 0; k <= wc; k++) begin
      check_out({tag, ".wait"}, u, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check_out({tag, ".done"}, u, 1'b1, 1'b1, exp_err);
    check({tag, ".rdata"}, rdata[u], exp_rdata);
    read[u]  = 1'b0;
    write[u] = 1'b0;
    tick();
    check_out({tag, ".end"}, u, 1'b0, 1'b0, 1'b0);
    check({tag, ".rdata_hold"}, rdata[u], exp_rdata);
  endtask

  initial begin
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; wdata[i] = '0; read[i] = 1'b0; write[i] = 1'b0;
    end
    tick();
    tick();
    check_out("reset", 0, 1'b0, 1'b0, 1'b0);
    check("reset.rdata", rdata[0], 32'h0);
    check("reset.state", 32'(dbg[0]), 32'h0);
    clr = 1'b1;
    tick();

    // WAIT_CYCLES = 2: write, read back, rdata held while idle
    run_txn("wr005", 0, 1'b1, 9'h005, 32'hDEADBEEF, 2, 1'b0, 32'h0);
    run_txn("rd005", 0, 1'b0, 9'h005, 32'h0, 2, 1'b0, 32'hDEADBEEF);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("idle.rdata", rdata[0], 32'hDEADBEEF);
    end

    // both requests at once: err only, no transaction
    addr[0] = 9'h010; read[0] = 1'b1; write[0] = 1'b1;
    tick();
    check_out("both", 0, 1'b0, 1'b0, 1'b1);
    read[0] = 1'b0; write[0] = 1'b0;
    tick();
    check_out("both.after", 0, 1'b0, 1'b0, 1'b0);
    run_txn("rd010", 0, 1'b0, 9'h010, 32'h0, 2, 1'b0, 32'h0);

    // WAIT_CYCLES = 0
    run_txn("w0.wr1ff", 1, 1'b1, 9'h1FF, 32'h1, 0, 1'b0, 32'h0);
    run_txn("w0.rd1ff", 1, 1'b0, 9'h1FF, 32'h0, 0, 1'b0, 32'h1);
    addr[1] = 9'h1FF; read[1] = 1'b1;
    tick();
    check_out("b2b.e0", 1, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("b2b.e1", 1, 1'b1, 1'b1, 1'b0);
    tick();
    check_out("b2b.e2", 1, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("b2b.e3", 1, 1'b1, 1'b0, 1'b0);
    read[1] = 1'b0;
    tick();
    check_out("b2b.e4", 1, 1'b1, 1'b1, 1'b0);
    check("b2b.rdata", rdata[1], 32'h1);
    tick();
    check_out("b2b.e5", 1, 1'b0, 1'b0, 1'b0);

    // reset during WAIT aborts the write
    addr[0] = 9'h020; wdata[0] = 32'hAAAA5555; write[0] = 1'b1;
    tick();
    tick();
    check("abort.state", 32'(dbg[0]), 32'h1);
    clr = 1'b0;
    tick();
    write[0] = 1'b0;
    check_out("abort.rst", 0, 1'b0, 1'b0, 1'b0);
    check("abort.rdata", rdata[0], 32'h0);
    check("abort.state_rst", 32'(dbg[0]), 32'h0);
    clr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort.no_done", 32'(done[0]), 32'h0);
    end
    run_txn("rd020", 0, 1'b0, 9'h020, 32'h0, 2, 1'b0, 32'h0);

    // DEPTH = 256: 0x100 is out of range and must not alias onto 0x000
    run_txn("d.wr000", 2, 1'b1, 9'h000, 32'h11111111, 2, 1'b0, 32'h0);
    run_txn("d.rd000", 2, 1'b0, 9'h000, 32'h0, 2, 1'b0, 32'h11111111);
    run_txn("d.rd100", 2, 1'b0, 9'h100, 32'h0, 2, 1'b1, 32'h0);
    run_txn("d.wr100", 2, 1'b1, 9'h100, 32'h12345678, 2, 1'b1, 32'h0);
    run_txn("d.rd000b", 2, 1'b0, 9'h000, 32'h0, 2, 1'b0, 32'h11111111);
    run_txn("d.rd0ff", 2, 1'b0, 9'h0FF, 32'h0, 2, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
